// File: rtl/ptp_ts_queue.sv
// ptp_ts_queue
// Show-ahead FIFO for PTP timestamp/tag records. When the queue is full and a
// write arrives without a read, the new record is either dropped or written
// over the oldest entry, depending on OVERWRITE. Both cases are counted in a
// saturating 16-bit drop counter.
//
// Ports
//   clk      : single clock for all logic
//   aclr     : asynchronous, active-high reset of pointers, count and drop counter
//   wrreq    : write request, sampled at rising clk
//   data     : write data (DW bits), sampled with wrreq
//   rdreq    : read acknowledge, pops the head entry
//   q        : head entry (show-ahead), valid whenever empty=0
//   empty    : queue holds no entries
//   full     : queue holds DEPTH entries
//   afull    : usedw >= AFULL_TH
//   usedw    : entry count, 0..DEPTH inclusive (AW+1 bits)
//   drop_cnt : saturating count of dropped or overwritten writes
//   drop_clr : synchronous clear of drop_cnt, wins over a same-cycle increment
module ptp_ts_queue #(
    parameter int DW        = 128,
    parameter int AW        = 4,
    parameter int AFULL_TH  = 2**AW - 2,
    parameter int OVERWRITE = 0
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          wrreq,
    input  logic [DW-1:0] data,
    input  logic          rdreq,
    output logic [DW-1:0] q,
    output logic          empty,
    output logic          full,
    output logic          afull,
    output logic [AW:0]   usedw,
    output logic [15:0]   drop_cnt,
    input  logic          drop_clr
);

    localparam int          DEPTH     = 2**AW;
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] ZERO_LVL  = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_LVL   = (AW+1)'(1'b1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
    localparam logic          OVR_EN  = (OVERWRITE != 0);

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   usedw_r;
    logic [15:0]   drop_cnt_r;

    logic          empty_s;
    logic          full_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic          ovr_s;
    logic          drop_s;
    logic          rd_adv_s;
    logic [AW:0]   usedw_nxt_s;

    // Status flags decoded from the registered entry count.
    always_comb begin
        empty_s = (usedw_r == ZERO_LVL);
        full_s  = (usedw_r == DEPTH_LVL);
    end

    // Transaction decode. A write is accepted when there is room, when a
    // same-cycle read frees a slot, or when overwrite mode is enabled.
    // A write into a full queue without a read is a drop in both modes;
    // in overwrite mode it also retires the oldest entry.
    always_comb begin
        rd_en_s  = rdreq & ~empty_s;
        wr_en_s  = wrreq & (~full_s | rdreq | OVR_EN);
        drop_s   = wrreq & full_s & ~rdreq;
        ovr_s    = drop_s & OVR_EN;
        rd_adv_s = rd_en_s | ovr_s;
    end

    // Next entry count: up on a lone write, down on a lone read, held on a
    // simultaneous read/write and on overwrite.
    always_comb begin
        usedw_nxt_s = usedw_r;
        case ({wr_en_s & ~rd_en_s & ~ovr_s, rd_en_s & ~wr_en_s})
            2'b10:   usedw_nxt_s = usedw_r + ONE_LVL;
            2'b01:   usedw_nxt_s = usedw_r - ONE_LVL;
            default: usedw_nxt_s = usedw_r;
        endcase
    end

    // Entry storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= data;
        end
    end

    // Pointers and entry count.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            usedw_r  <= ZERO_LVL;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            usedw_r <= usedw_nxt_s;
        end
    end

    // Saturating drop counter; clear has priority over increment.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_clr) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign q        = mem_r[rd_ptr_r];
    assign empty    = empty_s;
    assign full     = full_s;
    assign afull    = (usedw_r >= AFULL_LVL);
    assign usedw    = usedw_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_ptp_ts_queue.sv
// Directed testbench for ptp_ts_queue: one instance in drop mode (OVERWRITE=0)
// and one in overwrite mode (OVERWRITE=1), both DW=128, AW=4.
module tb_ptp_ts_queue;

    logic         clk;
    logic         aclr;
    logic         wrreq_a    [2];
    logic [127:0] data_a     [2];
    logic         rdreq_a    [2];
    logic         drop_clr_a [2];
    logic [127:0] q_a        [2];
    logic         empty_a    [2];
    logic         full_a     [2];
    logic         afull_a    [2];
    logic [4:0]   usedw_a    [2];
    logic [15:0]  drop_cnt_a [2];

    int checks = 0;
    int errors = 0;
    logic [127:0] model [$];

    ptp_ts_queue #(.DW(128), .AW(4), .OVERWRITE(0)) dut0 (
        .clk(clk), .aclr(aclr), .wrreq(wrreq_a[0]), .data(data_a[0]),
        .rdreq(rdreq_a[0]), .q(q_a[0]), .empty(empty_a[0]), .full(full_a[0]),
        .afull(afull_a[0]), .usedw(usedw_a[0]), .drop_cnt(drop_cnt_a[0]),
        .drop_clr(drop_clr_a[0])
    );

    ptp_ts_queue #(.DW(128), .AW(4), .OVERWRITE(1)) dut1 (
        .clk(clk), .aclr(aclr), .wrreq(wrreq_a[1]), .data(data_a[1]),
        .rdreq(rdreq_a[1]), .q(q_a[1]), .empty(empty_a[1]), .full(full_a[1]),
        .afull(afull_a[1]), .usedw(usedw_a[1]), .drop_cnt(drop_cnt_a[1]),
        .drop_clr(drop_clr_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs set before step() are sampled at the next rising edge;
    // outputs are examined 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input logic [127:0] d);
        wrreq_a[i] = 1'b1;
        rdreq_a[i] = 1'b0;
        data_a[i]  = d;
        step();
        wrreq_a[i] = 1'b0;
    endtask

    task automatic pop(input int i);
        wrreq_a[i] = 1'b0;
        rdreq_a[i] = 1'b1;
        step();
        rdreq_a[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            wrreq_a[i]    = 1'b0;
            rdreq_a[i]    = 1'b0;
            drop_clr_a[i] = 1'b0;
            data_a[i]     = 128'h0;
        end
        aclr = 1'b1;
        #3;
        chk("rst_usedw", 128'(usedw_a[0]), 128'd0);
        chk("rst_empty", 128'(empty_a[0]), 128'd1);
        chk("rst_full",  128'(full_a[0]),  128'd0);
        chk("rst_afull", 128'(afull_a[0]), 128'd0);
        chk("rst_drop",  128'(drop_cnt_a[0]), 128'd0);
        #4;
        aclr = 1'b0;

        // Three writes, three reads.
        for (int k = 1; k <= 3; k++) begin
            push(0, 128'(k));
            chk("w3_usedw", 128'(usedw_a[0]), 128'(k));
            chk("w3_q", q_a[0], 128'h1);
        end
        for (int k = 1; k <= 3; k++) begin
            chk("r3_q", q_a[0], 128'(k));
            pop(0);
        end
        chk("r3_empty", 128'(empty_a[0]), 128'd1);
        chk("r3_usedw", 128'(usedw_a[0]), 128'd0);

        // Read while empty is ignored.
        pop(0);
        chk("rdempty_usedw", 128'(usedw_a[0]), 128'd0);
        chk("rdempty_empty", 128'(empty_a[0]), 128'd1);

        // Simultaneous read and write on an empty queue.
        wrreq_a[0] = 1'b1; rdreq_a[0] = 1'b1; data_a[0] = 128'hAA;
        step();
        wrreq_a[0] = 1'b0; rdreq_a[0] = 1'b0;
        chk("wr_rd_empty_usedw", 128'(usedw_a[0]), 128'd1);
        chk("wr_rd_empty_q", q_a[0], 128'hAA);
        pop(0);
        chk("wr_rd_empty_drain", 128'(empty_a[0]), 128'd1);

        // Fill to full, watch afull, then drop one.
        for (int k = 1; k <= 16; k++) begin
            push(0, 128'(k));
            chk("fill_usedw", 128'(usedw_a[0]), 128'(k));
            chk("fill_afull", 128'(afull_a[0]), (k >= 14) ? 128'd1 : 128'd0);
            chk("fill_full",  128'(full_a[0]),  (k == 16) ? 128'd1 : 128'd0);
        end
        push(0, 128'h99);
        chk("drop_usedw", 128'(usedw_a[0]), 128'd16);
        chk("drop_cnt1",  128'(drop_cnt_a[0]), 128'd1);
        chk("drop_q",     q_a[0], 128'h1);
        for (int k = 1; k <= 16; k++) begin
            chk("drain_q", q_a[0], 128'(k));
            pop(0);
        end
        chk("drain_empty", 128'(empty_a[0]), 128'd1);

        // Refill, then a drop in the same cycle as drop_clr.
        for (int k = 1; k <= 16; k++) begin
            push(0, 128'h100 + 128'(k));
            model.push_back(128'h100 + 128'(k));
        end
        wrreq_a[0] = 1'b1; drop_clr_a[0] = 1'b1; data_a[0] = 128'hDEAD;
        step();
        wrreq_a[0] = 1'b0; drop_clr_a[0] = 1'b0;
        chk("clr_drop_cnt", 128'(drop_cnt_a[0]), 128'd0);
        chk("clr_q", q_a[0], 128'h101);

        // Full queue with simultaneous read and write across pointer wrap.
        for (int j = 0; j < 20; j++) begin
            chk("stream_q", q_a[0], model[0]);
            void'(model.pop_front());
            model.push_back(128'h200 + 128'(j));
            wrreq_a[0] = 1'b1; rdreq_a[0] = 1'b1; data_a[0] = 128'h200 + 128'(j);
            step();
            chk("stream_usedw", 128'(usedw_a[0]), 128'd16);
        end
        wrreq_a[0] = 1'b0; rdreq_a[0] = 1'b0;
        chk("stream_q_end", q_a[0], model[0]);
        chk("stream_drop", 128'(drop_cnt_a[0]), 128'd0);

        // Saturate the drop counter.
        wrreq_a[0] = 1'b1; data_a[0] = 128'h55;
        repeat (65540) step();
        wrreq_a[0] = 1'b0;
        chk("sat_drop", 128'(drop_cnt_a[0]), 128'hFFFF);
        chk("sat_usedw", 128'(usedw_a[0]), 128'd16);

        // Asynchronous reset between edges, then a write as it releases.
        aclr = 1'b1;
        #1;
        chk("aclr_usedw", 128'(usedw_a[0]), 128'd0);
        chk("aclr_empty", 128'(empty_a[0]), 128'd1);
        chk("aclr_full",  128'(full_a[0]),  128'd0);
        chk("aclr_drop",  128'(drop_cnt_a[0]), 128'd0);
        #1;
        aclr = 1'b0;
        push(0, 128'h77);
        chk("post_aclr_usedw", 128'(usedw_a[0]), 128'd1);
        chk("post_aclr_q", q_a[0], 128'h77);

        // Overwrite mode: fill with 1..16, then write 0x11.
        for (int k = 1; k <= 16; k++) begin
            push(1, 128'(k));
        end
        chk("ovr_full", 128'(full_a[1]), 128'd1);
        push(1, 128'h11);
        chk("ovr_usedw", 128'(usedw_a[1]), 128'd16);
        chk("ovr_drop",  128'(drop_cnt_a[1]), 128'd1);
        chk("ovr_q",     q_a[1], 128'h2);
        for (int k = 2; k <= 17; k++) begin
            chk("ovr_drain_q", q_a[1], 128'(k));
            pop(1);
        end
        chk("ovr_empty", 128'(empty_a[1]), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
